// File: rtl/imm_decode_stage_if.sv
// Handshake and decoded-operand bus between fetch, the decode stage and execute.
interface imm_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  imme_sel;
    logic [31:0] i_imme;
    logic [31:0] s_imme;
    logic [31:0] b_imme;
    logic [31:0] uj_imme;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] pc_out;
    logic        illegal;

    // Upstream/downstream environment view.
    modport master (
        output in_valid, instr, pc, flush, out_ready,
        input  in_ready, out_valid, imme_sel, i_imme, s_imme, b_imme, uj_imme,
               rs1_addr, rs2_addr, rd_addr, pc_out, illegal
    );

    // Decode stage view.
    modport slave (
        input  in_valid, instr, pc, flush, out_ready,
        output in_ready, out_valid, imme_sel, i_imme, s_imme, b_imme, uj_imme,
               rs1_addr, rs2_addr, rd_addr, pc_out, illegal
    );
endinterface

// File: rtl/imm_decode_stage.sv
// RV32I immediate/operand decode stage behind a 2-entry skid buffer.
// in_ready comes straight from a flop, so out_ready never reaches it combinationally.
module imm_decode_stage (
    input logic            clk,
    input logic            rst_n,
    imm_decode_stage_if.slave bus
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    typedef struct packed {
        logic        illegal;
        logic [2:0]  imme_sel;
        logic [31:0] i_imme;
        logic [31:0] s_imme;
        logic [31:0] b_imme;
        logic [31:0] uj_imme;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] pc;
    } entry_t;

    state_e state_q, state_d;
    entry_t dec;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   in_xfer;
    logic   out_xfer;
    logic [6:0] opcode;

    assign opcode   = bus.instr[6:0];
    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready;

    // Combinational decode of the incoming instruction word.
    always_comb begin
        dec          = '0;
        dec.pc       = bus.pc;
        dec.rs1_addr = bus.instr[19:15];
        dec.rs2_addr = bus.instr[24:20];
        dec.rd_addr  = bus.instr[11:7];
        dec.i_imme   = {{20{bus.instr[31]}}, bus.instr[31:20]};
        dec.s_imme   = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
        dec.b_imme   = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                        bus.instr[11:8], 1'b0};
        dec.uj_imme  = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                        bus.instr[30:21], 1'b0};
        case (opcode)
            7'b0110011:                         dec.imme_sel = 3'b000;
            7'b0010011, 7'b0000011, 7'b1100111: dec.imme_sel = 3'b001;
            7'b0100011:                         dec.imme_sel = 3'b011;
            7'b1100011:                         dec.imme_sel = 3'b010;
            7'b1101111:                         dec.imme_sel = 3'b101;
            default: begin
                // Unsupported opcodes (lui/auipc included) still flow through, flagged.
                dec.imme_sel = 3'b000;
                dec.illegal  = 1'b1;
            end
        endcase
    end

    // Skid-buffer next state: which entry loads and where the buffer goes.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            // Data registers keep their contents; out_valid=0 marks them dead.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        out_d   = dec;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        out_d = dec;
                    end else if (in_xfer) begin
                        skid_d  = dec;
                        state_d = StTwo;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_xfer) begin
                        out_d   = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State, handshake flags and entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != StTwo);
            out_valid_q <= (state_d != StEmpty);
            out_q       <= out_d;
            skid_q      <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.imme_sel  = out_q.imme_sel;
    assign bus.i_imme    = out_q.i_imme;
    assign bus.s_imme    = out_q.s_imme;
    assign bus.b_imme    = out_q.b_imme;
    assign bus.uj_imme   = out_q.uj_imme;
    assign bus.rs1_addr  = out_q.rs1_addr;
    assign bus.rs2_addr  = out_q.rs2_addr;
    assign bus.rd_addr   = out_q.rd_addr;
    assign bus.pc_out    = out_q.pc;
    assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: accepted instructions are decoded by an
// arithmetic reference model and queued; a monitor pops on every output transfer.
module tb_imm_decode_stage;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  sel;
        logic        ill;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] j_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exp_t;

    logic clk;
    logic rst_n;
    imm_decode_stage_if bus ();

    imm_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    exp_t sb[$];
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic [6:0] legal_ops [7] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode: field values assembled with arithmetic, sign bit weighted negative.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
        exp_t e;
        int   sgn;
        int   v;
        sgn   = int'(ins[31]);
        e.pc  = p;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        v = int'(ins[30:20]) - sgn * 2048;
        e.i_imm = v;
        v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - sgn * 2048;
        e.s_imm = v;
        v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - sgn * 4096;
        e.b_imm = v;
        v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
            - sgn * 1048576;
        e.j_imm = v;
        e.ill = 1'b0;
        case (ins[6:0])
            7'h33:               e.sel = 3'd0;
            7'h13, 7'h03, 7'h67: e.sel = 3'd1;
            7'h23:               e.sel = 3'd3;
            7'h63:               e.sel = 3'd2;
            7'h6F:               e.sel = 3'd5;
            default: begin
                e.sel = 3'd0;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr(input bit legal_only);
        logic [31:0] r;
        r = $urandom;
        if (legal_only || $urandom_range(3) != 0) r[6:0] = legal_ops[$urandom_range(6)];
        return r;
    endfunction

    // Scoreboard: pop/compare on output transfers, push on input transfers.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || bus.flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_output", bus.pc_out, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    check("pc_out", bus.pc_out, e.pc);
                    check("imme_sel", 32'(bus.imme_sel), 32'(e.sel));
                    check("illegal", 32'(bus.illegal), 32'(e.ill));
                    check("i_imme", bus.i_imme, e.i_imm);
                    check("s_imme", bus.s_imme, e.s_imm);
                    check("b_imme", bus.b_imme, e.b_imm);
                    check("uj_imme", bus.uj_imme, e.j_imm);
                    check("rs1_addr", 32'(bus.rs1_addr), 32'(e.rs1));
                    check("rs2_addr", 32'(bus.rs2_addr), 32'(e.rs2));
                    check("rd_addr", 32'(bus.rd_addr), 32'(e.rd));
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.instr, bus.pc));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.pc       = pc_ctr;
        pc_ctr       = pc_ctr + 32'd4;
    endtask

    // Called at posedge+1 with in_ready known high; returns at the following negedge.
    task automatic send(input logic [31:0] ins);
        present(ins);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_data"}, bus.i_imme | bus.s_imme | bus.b_imme | bus.uj_imme | bus.pc_out,
              32'd0);
        check({tag, "_fields"}, 32'({bus.imme_sel, bus.illegal, bus.rs1_addr, bus.rs2_addr,
              bus.rd_addr}), 32'd0);
    endtask

    initial begin
        int k;
        int n0;
        int stalls;
        bit acc;
        logic [31:0] v[4];

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.pc        = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc();

        // Directed decode values, each one cycle after acceptance.
        send(32'hFFF00093);
        check("addi_sel", 32'(bus.imme_sel), 32'd1);
        check("addi_i_imme", bus.i_imme, 32'hFFFF_FFFF);
        check("addi_rd", 32'(bus.rd_addr), 32'd1);
        cyc();
        send(32'h0020A423);
        check("sw_sel", 32'(bus.imme_sel), 32'd3);
        check("sw_s_imme", bus.s_imme, 32'h0000_0008);
        check("sw_rs", 32'({bus.rs1_addr, bus.rs2_addr}), 32'({5'd1, 5'd2}));
        cyc();
        send(32'hFE000EE3);
        check("beq_sel", 32'(bus.imme_sel), 32'd2);
        check("beq_b_imme", bus.b_imme, 32'hFFFF_FFFC);
        cyc();
        send(32'h001000EF);
        check("jal_sel", 32'(bus.imme_sel), 32'd5);
        check("jal_uj_imme", bus.uj_imme, 32'h0000_0800);
        cyc();
        send(32'h00000037);
        check("lui_illegal", 32'(bus.illegal), 32'd1);
        check("lui_sel", 32'(bus.imme_sel), 32'd0);
        cyc();
        send(32'h002081B3);
        check("add_sel", 32'(bus.imme_sel), 32'd0);
        check("add_illegal", 32'(bus.illegal), 32'd0);
        cyc();

        // Backpressure: only two absorbed, then all four drain back to back.
        for (int i = 0; i < 4; i++) v[i] = rand_instr(1'b1);
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            present(v[k]);
            pc_ctr = pc_ctr - 32'd4;
            @(negedge clk);
            acc = bus.in_ready;
            cyc();
            if (acc) begin
                k++;
                pc_ctr = pc_ctr + 32'd4;
            end
        end
        check("bp_accepted", 32'(k), 32'd2);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        n0 = n_out;
        for (int c = 0; c < 4; c++) begin
            if (k < 4) begin
                present(v[k]);
                pc_ctr = pc_ctr - 32'd4;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            acc = bus.in_ready && bus.in_valid;
            cyc();
            if (acc) begin
                k++;
                pc_ctr = pc_ctr + 32'd4;
            end
        end
        bus.in_valid = 1'b0;
        check("bp_accepted_all", 32'(k), 32'd4);
        check("bp_no_gaps", 32'(n_out - n0), 32'd4);

        // Flush in TWO with a same-cycle input.
        bus.out_ready = 1'b0;
        present(rand_instr(1'b1));
        cyc();
        present(rand_instr(1'b1));
        cyc();
        present(rand_instr(1'b1));
        bus.flush = 1'b1;
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        n0 = n_out;
        repeat (3) cyc();
        check("flush_nothing_emerges", 32'(n_out - n0), 32'd0);
        send(rand_instr(1'b1));
        cyc();

        // Asynchronous reset while holding two entries.
        bus.out_ready = 1'b0;
        present(32'hFFF0_8093);
        cyc();
        present(32'h8020_A4A3);
        cyc();
        bus.in_valid = 1'b0;
        check("pre_reset_full", 32'(bus.in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        cyc();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        send(rand_instr(1'b1));
        cyc();

        // Random traffic with backpressure, illegal opcodes and occasional flush.
        for (int c = 0; c < 300; c++) begin
            if (!bus.in_valid || acc) begin
                bus.instr = rand_instr(1'b0);
                bus.pc    = pc_ctr;
                pc_ctr    = pc_ctr + 32'd4;
            end
            bus.in_valid  = ($urandom_range(9) < 7);
            bus.out_ready = ($urandom_range(9) < 7);
            bus.flush     = ($urandom_range(99) < 3);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) cyc();
        check("drain_empty", 32'(sb.size()), 32'd0);
        cyc();

        // Throughput: 100 legal instructions, one per cycle in and out.
        n0     = n_out;
        stalls = 0;
        for (int c = 0; c < 100; c++) begin
            present(rand_instr(1'b1));
            @(negedge clk);
            if (!bus.in_ready) stalls++;
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc();
        check("tput_stalls", 32'(stalls), 32'd0);
        check("tput_outputs", 32'(n_out - n0), 32'd100);
        check("tput_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
